// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor controller.
package serial_sub_pkg;

  // Default operand/result width in bits.
  localparam int unsigned DefaultWidth = 8;

  // Controller states, 2-bit encoding.
  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StDone = 2'b10
  } state_t;

endpackage

// File: rtl/fullsub_bit.sv
// One-bit full subtractor cell: computes a - b - c.
module fullsub_bit (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic d_o,
  output logic bo_o
);

  // Difference bit and borrow-out of a single bit position.
  always_comb begin
    d_o  = a_i ^ b_i ^ c_i;
    bo_o = (~a_i & b_i) | (~(a_i ^ b_i) & c_i);
  end

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor: computes a - b - bin over WIDTH cycles, LSB first, using one
// fullsub_bit cell. Start/done handshake; result and borrow-out held until the next
// result is produced.
// Optional feature: define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_sub_ctrl
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LastBit = CNT_W'(WIDTH - 1);

  state_t           state_q;
  logic [CNT_W-1:0] count_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] diff_sh_q;
  logic [WIDTH-1:0] diff_sh_d;
  logic             borrow_q;
  logic             cell_d;
  logic             cell_bo;

`ifdef SERIAL_SUB_OVF_EN
  // Operand sign bits captured at accept; the shift registers lose them during RUN.
  logic a_msb_q;
  logic b_msb_q;
`endif

  fullsub_bit u_cell (
    .a_i  (a_sh_q[0]),
    .b_i  (b_sh_q[0]),
    .c_i  (borrow_q),
    .d_o  (cell_d),
    .bo_o (cell_bo)
  );

  // Difference shift register with this cycle's bit entering at the MSB.
  always_comb begin
    diff_sh_d = {cell_d, diff_sh_q[WIDTH-1:1]};
  end

  // FSM, counter, shift registers, borrow flop and registered handshake/result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      count_q   <= '0;
      a_sh_q    <= '0;
      b_sh_q    <= '0;
      diff_sh_q <= '0;
      borrow_q  <= 1'b0;
      ready     <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      diff      <= '0;
      bout      <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q   <= 1'b0;
      b_msb_q   <= 1'b0;
      ovf       <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            a_sh_q   <= a;
            b_sh_q   <= b;
            borrow_q <= bin;
            count_q  <= '0;
            state_q  <= StRun;
            ready    <= 1'b0;
            busy     <= 1'b1;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q  <= a[WIDTH-1];
            b_msb_q  <= b[WIDTH-1];
`endif
          end
        end
        StRun: begin
          diff_sh_q <= diff_sh_d;
          borrow_q  <= cell_bo;
          a_sh_q    <= {1'b0, a_sh_q[WIDTH-1:1]};
          b_sh_q    <= {1'b0, b_sh_q[WIDTH-1:1]};
          if (count_q == LastBit) begin
            // Last bit: publish the result; the counter stays at its maximum.
            state_q <= StDone;
            busy    <= 1'b0;
            done    <= 1'b1;
            diff    <= diff_sh_d;
            bout    <= cell_bo;
`ifdef SERIAL_SUB_OVF_EN
            ovf     <= (a_msb_q ^ b_msb_q) & (cell_d ^ a_msb_q);
`endif
          end else begin
            count_q <= count_q + CNT_W'(1);
          end
        end
        StDone: begin
          state_q <= StIdle;
          ready   <= 1'b1;
        end
        default: begin
          state_q <= StIdle;
          ready   <= 1'b1;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed and random bench for serial_sub_ctrl (WIDTH = 8).
module tb_serial_sub_ctrl;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int errors = 0;
  int checks = 0;

  serial_sub_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation and wait (bounded) for done. lat = cycles from the start cycle to
  // done (-1 on timeout); proto_bad set if ready&busy or !busy before done is seen.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bv_in,
                        output int lat, output bit proto_bad);
    a = av;
    b = bv;
    bin = bv_in;
    start = 1'b1;
    step();
    start = 1'b0;
    lat = -1;
    proto_bad = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      if (ready && busy) proto_bad = 1'b1;
      if (done) begin
        lat = i;
        break;
      end
      if (!busy) proto_bad = 1'b1;
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (diff !== 8'h00) begin errors++; $display("FAIL reset_diff got=%h exp=00", diff); end
    checks++; if (bout !== 1'b0) begin errors++; $display("FAIL reset_bout got=%b exp=0", bout); end
  endtask

  task automatic test_basic();
    int lat;
    bit pb;
    run_op(8'h05, 8'h03, 1'b0, lat, pb);
    checks++; if (lat !== 9) begin errors++; $display("FAIL basic_latency got=%0d exp=9", lat); end
    checks++; if (diff !== 8'h02) begin errors++; $display("FAIL basic1_diff got=%h exp=02", diff); end
    checks++; if (bout !== 1'b0) begin errors++; $display("FAIL basic1_bout got=%b exp=0", bout); end
    checks++; if (pb !== 1'b0) begin errors++; $display("FAIL basic1_protocol got=%b exp=0", pb); end
    step();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_width got=%b exp=0", done); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL ready_after_done got=%b exp=1", ready); end
    run_op(8'h03, 8'h05, 1'b0, lat, pb);
    checks++; if (diff !== 8'hFE) begin errors++; $display("FAIL basic2_diff got=%h exp=fe", diff); end
    checks++; if (bout !== 1'b1) begin errors++; $display("FAIL basic2_bout got=%b exp=1", bout); end
    step();
    run_op(8'h00, 8'h00, 1'b1, lat, pb);
    checks++; if (diff !== 8'hFF) begin errors++; $display("FAIL basic3_diff got=%h exp=ff", diff); end
    checks++; if (bout !== 1'b1) begin errors++; $display("FAIL basic3_bout got=%b exp=1", bout); end
    step();
  endtask

  // Start during RUN is ignored; back-to-back start accepted at T+10; result held until DONE.
  task automatic test_back_to_back();
    int t;
    a = 8'h05; b = 8'h03; bin = 1'b0; start = 1'b1;
    step();                        // T+1
    start = 1'b0;
    step();                        // T+2
    step();                        // T+3
    a = 8'hFF; b = 8'h01; bin = 1'b1; start = 1'b1;
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL run_ready got=%b exp=0", ready); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL run_busy got=%b exp=1", busy); end
    step();                        // T+4
    start = 1'b0;
    t = 4;
    while (!done && t < 20) begin
      step();
      t++;
    end
    checks++; if (t !== 9) begin errors++; $display("FAIL ignore_latency got=%0d exp=9", t); end
    checks++; if (diff !== 8'h02) begin errors++; $display("FAIL ignore_diff got=%h exp=02", diff); end
    checks++; if (bout !== 1'b0) begin errors++; $display("FAIL ignore_bout got=%b exp=0", bout); end
    step();                        // T+10
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got=%b exp=1", ready); end
    a = 8'h10; b = 8'h01; bin = 1'b0; start = 1'b1;
    step();                        // T+11
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy got=%b exp=1", busy); end
    checks++; if (diff !== 8'h02) begin errors++; $display("FAIL b2b_hold got=%h exp=02", diff); end
    t = 11;
    while (!done && t < 30) begin
      step();
      t++;
    end
    checks++; if (t !== 19) begin errors++; $display("FAIL b2b_latency got=%0d exp=19", t); end
    checks++; if (diff !== 8'h0F) begin errors++; $display("FAIL b2b_diff got=%h exp=0f", diff); end
    step();
  endtask

  task automatic test_reset_mid_run();
    int lat;
    bit pb;
    bit seen_done;
    a = 8'h05; b = 8'h03; bin = 1'b0; start = 1'b1;
    step();                        // T+1
    start = 1'b0;
    step();
    step();
    step();                        // T+4
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL abort_ready got=%b exp=1", ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", busy); end
    checks++; if (diff !== 8'h00) begin errors++; $display("FAIL abort_diff got=%h exp=00", diff); end
    checks++; if (bout !== 1'b0) begin errors++; $display("FAIL abort_bout got=%b exp=0", bout); end
    seen_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (done) seen_done = 1'b1;
      step();
    end
    checks++; if (seen_done !== 1'b0) begin errors++; $display("FAIL abort_no_done got=%b exp=0", seen_done); end
    // rst wins over start in the same cycle
    a = 8'h33; b = 8'h11; rst = 1'b1; start = 1'b1;
    step();
    rst = 1'b0; start = 1'b0;
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_priority_busy got=%b exp=0", busy); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rst_priority_ready got=%b exp=1", ready); end
    run_op(8'hA0, 8'h0A, 1'b0, lat, pb);
    checks++; if (lat !== 9) begin errors++; $display("FAIL post_rst_latency got=%0d exp=9", lat); end
    checks++; if (diff !== 8'h96) begin errors++; $display("FAIL post_rst_diff got=%h exp=96", diff); end
    checks++; if (bout !== 1'b0) begin errors++; $display("FAIL post_rst_bout got=%b exp=0", bout); end
    step();
  endtask

`ifdef SERIAL_SUB_OVF_EN
  task automatic test_ovf();
    int lat;
    bit pb;
    run_op(8'h80, 8'h01, 1'b0, lat, pb);
    checks++; if (diff !== 8'h7F) begin errors++; $display("FAIL ovf1_diff got=%h exp=7f", diff); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf1_ovf got=%b exp=1", ovf); end
    step();
    run_op(8'h10, 8'h01, 1'b0, lat, pb);
    checks++; if (diff !== 8'h0F) begin errors++; $display("FAIL ovf2_diff got=%h exp=0f", diff); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf2_ovf got=%b exp=0", ovf); end
    step();
  endtask
`endif

  task automatic test_random();
    int lat;
    bit pb;
    logic [W-1:0] av;
    logic [W-1:0] bv;
    logic         cv;
    logic [W:0]   ref_v;
    for (int n = 0; n < 1000; n++) begin
      av = W'($urandom_range(0, 255));
      bv = W'($urandom_range(0, 255));
      cv = 1'($urandom_range(0, 1));
      ref_v = {1'b0, av} - {1'b0, bv} - {{W{1'b0}}, cv};
      run_op(av, bv, cv, lat, pb);
      checks++;
      if (lat !== 9 || pb !== 1'b0) begin
        errors++;
        $display("FAIL rand_handshake op=%0d lat=%0d exp=9 proto_bad=%b", n, lat, pb);
      end
      checks++;
      if (diff !== ref_v[W-1:0] || bout !== ref_v[W]) begin
        errors++;
        $display("FAIL rand_result a=%h b=%h bin=%b got=%b_%h exp=%b_%h",
                 av, bv, cv, bout, diff, ref_v[W], ref_v[W-1:0]);
      end
`ifdef SERIAL_SUB_OVF_EN
      checks++;
      if (ovf !== ((av[W-1] ^ bv[W-1]) & (ref_v[W-1] ^ av[W-1]))) begin
        errors++;
        $display("FAIL rand_ovf a=%h b=%h got=%b", av, bv, ovf);
      end
`endif
      step();
      checks++;
      if (done !== 1'b0 || ready !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL rand_done_width done=%b ready=%b busy=%b exp=0/1/0", done, ready, busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_reset_mid_run();
`ifdef SERIAL_SUB_OVF_EN
    test_ovf();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
